// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular FIFO of {pc, inst, pred_taken}
// with registered count, flush for redirects, and no bypass or push-through.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic             out_pred_taken,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam int ENTRY_W = 65;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic               push, pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; a write dropped by flush/rst is unreachable anyway.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_pc, in_inst, in_pred_taken};
    end

    always_comb begin
        head = '0;
        if (!empty) head = mem_q[rd_ptr_q];
    end

    assign {out_pc, out_inst, out_pred_taken} = head;

endmodule
